// File: rtl/midi_rx_queue_if.sv
// Message stream handshake between the MIDI receive queue and its consumer.
// The master drives the head message and valid; the slave returns ready.
interface midi_rx_queue_if;
    logic [23:0] msg_data;
    logic        msg_valid;
    logic        msg_ready;

    modport master (
        output msg_data,
        output msg_valid,
        input  msg_ready
    );

    modport slave (
        input  msg_data,
        input  msg_valid,
        output msg_ready
    );
endinterface

// File: rtl/midi_rx_queue.sv
// MIDI input stage: UART receiver, running-status parser with channel filter and
// Note-Off normalisation, and a first-word-fall-through message queue.
module midi_rx_queue #(
    parameter int unsigned CLK_HZ        = 50_000_000,
    parameter int unsigned BAUD          = 31250,
    parameter int unsigned DEPTH         = 8,
    parameter logic [15:0] CHAN_MASK     = 16'hFFFF,
    parameter bit          NOTE_OFF_NORM = 1'b1
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     midi_in,
    midi_rx_queue_if.master          msg,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    input  logic                     clr_overflow,
    output logic                     rx_err
);

    localparam int unsigned DIV   = CLK_HZ / BAUD;
    localparam int unsigned CNT_W = $clog2(DIV);
    localparam int unsigned PTR_W = $clog2(DEPTH);

    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(DIV / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(DIV - 1);
    localparam logic [PTR_W:0]   FULL_CNT  = (PTR_W + 1)'(DEPTH);

    // ------------------------------------------------------------------
    // Input synchroniser and edge history
    // ------------------------------------------------------------------
    logic sync1_q, sync2_q, prev_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
        end else begin
            sync1_q <= midi_in;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    // ------------------------------------------------------------------
    // Receiver FSM
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} rx_state_e;

    rx_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             stop_tick, byte_valid, frame_err;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        bit_d   = bit_q;
        shift_d = shift_q;
        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                // Only a genuine high-to-low edge starts a frame, so a line held
                // low after a framing error must first return high.
                if (prev_q && !sync2_q) begin
                    state_d = StStart;
                end
            end
            StStart: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = sync2_q ? StIdle : StData;
                end
            end
            StData: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    shift_d = {sync2_q, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = StStop;
                    end
                end
            end
            StStop: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    state_d = StIdle;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        stop_tick  = (state_q == StStop) && (cnt_q == BIT_LAST);
        byte_valid = stop_tick && sync2_q;
        frame_err  = stop_tick && !sync2_q;
    end

    // ------------------------------------------------------------------
    // Parser: running status, filter, normalisation
    // ------------------------------------------------------------------
    logic [7:0]  status_q, status_d;   // bit 7 set means running status is valid
    logic [7:0]  d1_q, d1_d;
    logic        have_d1_q, have_d1_d;
    logic        emit_valid_q, emit_valid_d;
    logic [23:0] emit_data_q, emit_data_d;
    logic        rx_err_q;
    logic        one_byte;
    logic [23:0] chan_msg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            status_q     <= '0;
            d1_q         <= '0;
            have_d1_q    <= 1'b0;
            emit_valid_q <= 1'b0;
            emit_data_q  <= '0;
            rx_err_q     <= 1'b0;
        end else begin
            status_q     <= status_d;
            d1_q         <= d1_d;
            have_d1_q    <= have_d1_d;
            emit_valid_q <= emit_valid_d;
            emit_data_q  <= emit_data_d;
            rx_err_q     <= frame_err;
        end
    end

    always_comb begin
        status_d     = status_q;
        d1_d         = d1_q;
        have_d1_d    = have_d1_q;
        emit_valid_d = 1'b0;
        emit_data_d  = emit_data_q;
        one_byte     = (status_q[7:5] == 3'b110);   // Cn program change, Dn pressure
        chan_msg     = have_d1_q ? {status_q, d1_q, shift_q} : {status_q, shift_q, 8'h00};

        if (NOTE_OFF_NORM && chan_msg[23:20] == 4'h9 && chan_msg[7:0] == 8'h00) begin
            chan_msg[23:20] = 4'h8;
        end

        if (frame_err) begin
            status_d  = '0;
            have_d1_d = 1'b0;
        end else if (byte_valid) begin
            if (shift_q[7:3] == 5'b11111) begin
                // Real-time bytes slip through without disturbing a partial message.
                emit_valid_d = 1'b1;
                emit_data_d  = {shift_q, 16'h0000};
            end else if (shift_q[7:4] == 4'hF) begin
                status_d  = '0;
                have_d1_d = 1'b0;
            end else if (shift_q[7]) begin
                status_d  = shift_q;
                have_d1_d = 1'b0;
            end else if (status_q[7]) begin
                if (!have_d1_q && !one_byte) begin
                    d1_d      = shift_q;
                    have_d1_d = 1'b1;
                end else begin
                    have_d1_d    = 1'b0;
                    emit_valid_d = CHAN_MASK[status_q[3:0]];
                    emit_data_d  = chan_msg;
                end
            end
        end
    end

    assign rx_err = rx_err_q;

    // ------------------------------------------------------------------
    // Message queue
    // ------------------------------------------------------------------
    logic [23:0]      mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]   count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             push, pop, full, wr_en, drop;

    always_comb begin
        push  = emit_valid_q;
        pop   = msg.msg_valid && msg.msg_ready;
        full  = (count_q == FULL_CNT);
        // A pop on a full queue frees the slot the push is about to use.
        wr_en = push && (!full || pop);
        drop  = push && full && !pop;

        count_d = count_q;
        if (wr_en && !pop) begin
            count_d = count_q + 1'b1;
        end else if (!wr_en && pop) begin
            count_d = count_q - 1'b1;
        end

        overflow_d = overflow_q;
        if (drop) begin
            overflow_d = 1'b1;
        end else if (clr_overflow) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage needs no reset: the head is masked to zero whenever the queue is empty.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= emit_data_q;
        end
    end

    assign msg.msg_valid = (count_q != '0);
    assign msg.msg_data  = msg.msg_valid ? mem_q[rd_ptr_q] : 24'h0;
    assign count         = count_q;
    assign overflow      = overflow_q;

endmodule

// File: tb/tb_midi_rx_queue.sv
// Randomised and directed bench for midi_rx_queue: two instances with different filter
// and normalisation settings share one serial line and are compared against a byte-level model.
module tb_midi_rx_queue;

    localparam int unsigned DIV   = 32;
    localparam int unsigned DEPTH = 4;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       midi_in = 1'b1;
    logic       clr_overflow = 1'b0;
    logic [2:0] count_a, count_b;
    logic       ovf_a, ovf_b, err_a, err_b;

    midi_rx_queue_if if_a ();
    midi_rx_queue_if if_b ();

    always #5 clk = ~clk;

    midi_rx_queue #(
        .CLK_HZ       (1_000_000),
        .BAUD         (31250),
        .DEPTH        (DEPTH),
        .CHAN_MASK    (16'hFFFF),
        .NOTE_OFF_NORM(1'b1)
    ) dut_a (
        .clk         (clk),
        .reset_n     (reset_n),
        .midi_in     (midi_in),
        .msg         (if_a),
        .count       (count_a),
        .overflow    (ovf_a),
        .clr_overflow(clr_overflow),
        .rx_err      (err_a)
    );

    midi_rx_queue #(
        .CLK_HZ       (1_000_000),
        .BAUD         (31250),
        .DEPTH        (DEPTH),
        .CHAN_MASK    (16'h0001),
        .NOTE_OFF_NORM(1'b0)
    ) dut_b (
        .clk         (clk),
        .reset_n     (reset_n),
        .midi_in     (midi_in),
        .msg         (if_b),
        .count       (count_b),
        .overflow    (ovf_b),
        .clr_overflow(clr_overflow),
        .rx_err      (err_b)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: config 0 = all channels + normalisation, config 1 = channel 0 only, raw.
    int          rs [2];
    int          nd [2];
    int          dat [2][2];
    bit          movf [2];
    logic [23:0] q0 [$];
    logic [23:0] q1 [$];

    function automatic int qsize(input int c);
        return (c == 0) ? q0.size() : q1.size();
    endfunction

    function automatic logic [23:0] qfront(input int c);
        return (c == 0) ? q0[0] : q1[0];
    endfunction

    task automatic model_emit(input int c, input logic [23:0] m);
        if (qsize(c) == DEPTH) movf[c] = 1'b1;
        else if (c == 0) q0.push_back(m);
        else q1.push_back(m);
    endtask

    task automatic model_reset();
        for (int c = 0; c < 2; c++) begin
            rs[c] = -1;
            nd[c] = 0;
            movf[c] = 1'b0;
        end
        q0.delete();
        q1.delete();
    endtask

    task automatic model_frame_err();
        for (int c = 0; c < 2; c++) begin
            rs[c] = -1;
            nd[c] = 0;
        end
    endtask

    task automatic model_byte(input int b);
        int need, st, d2;
        for (int c = 0; c < 2; c++) begin
            if (b >= 'hF8) begin
                model_emit(c, 24'(b << 16));
            end else if (b >= 'hF0) begin
                rs[c] = -1;
                nd[c] = 0;
            end else if (b >= 'h80) begin
                rs[c] = b;
                nd[c] = 0;
            end else if (rs[c] >= 0) begin
                need = ((rs[c] >> 4) == 12 || (rs[c] >> 4) == 13) ? 1 : 2;
                dat[c][nd[c]] = b;
                nd[c]++;
                if (nd[c] == need) begin
                    nd[c] = 0;
                    st = rs[c];
                    d2 = (need == 2) ? dat[c][1] : 0;
                    if (c == 0 || (st % 16) == 0) begin
                        if (c == 0 && (st / 16) == 9 && d2 == 0) st = 'h80 + (st % 16);
                        model_emit(c, 24'(st * 65536 + dat[c][0] * 256 + d2));
                    end
                end
            end
        end
    endtask

    // mode: 0 plain, 1 check valid latency, 2 pop instance A in the push cycle, 3 check rx_err
    task automatic send_byte(input logic [7:0] b, input logic stop_val, input int mode);
        @(posedge clk);
        #1 midi_in = 1'b0;
        for (int i = 0; i < 8; i++) begin
            repeat (DIV) @(posedge clk);
            #1 midi_in = b[i];
        end
        repeat (DIV) @(posedge clk);
        #1 midi_in = stop_val;
        repeat (18) @(posedge clk);
        #1;
        if (mode == 3) check("rx_err_before", err_a, 0);
        @(posedge clk);
        #1;
        if (mode == 1) check("valid_before", if_a.msg_valid, 0);
        if (mode == 2) begin
            check("full_count", count_a, 4);
            check("full_head", if_a.msg_data, qfront(0));
            if_a.msg_ready = 1'b1;
        end
        if (mode == 3) begin
            check("rx_err_pulse_a", err_a, 1);
            check("rx_err_pulse_b", err_b, 1);
        end
        @(posedge clk);
        #1;
        if (mode == 1) check("valid_rise", if_a.msg_valid, 1);
        if (mode == 2) begin
            if_a.msg_ready = 1'b0;
            void'(q0.pop_front());
        end
        if (mode == 3) check("rx_err_end", err_a, 0);
        repeat (12) @(posedge clk);
        #1 midi_in = 1'b1;
        repeat (2) @(posedge clk);
        if (stop_val) model_byte(int'(b));
        else model_frame_err();
    endtask

    task automatic check_state();
        check("count_a", count_a, qsize(0));
        check("count_b", count_b, qsize(1));
        check("overflow_a", ovf_a, movf[0]);
        check("overflow_b", ovf_b, movf[1]);
    endtask

    task automatic drain(input int c);
        while (qsize(c) > 0) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1 check("hold_data", (c == 0) ? if_a.msg_data : if_b.msg_data, qfront(c));
            end
            @(posedge clk);
            #1;
            check("pop_valid", (c == 0) ? if_a.msg_valid : if_b.msg_valid, 1);
            check("pop_data", (c == 0) ? if_a.msg_data : if_b.msg_data, qfront(c));
            if (c == 0) if_a.msg_ready = 1'b1;
            else if_b.msg_ready = 1'b1;
            @(posedge clk);
            #1;
            if_a.msg_ready = 1'b0;
            if_b.msg_ready = 1'b0;
            if (c == 0) void'(q0.pop_front());
            else void'(q1.pop_front());
        end
        check("empty_valid", (c == 0) ? if_a.msg_valid : if_b.msg_valid, 0);
        check("empty_data", (c == 0) ? if_a.msg_data : if_b.msg_data, 0);
    endtask

    task automatic drain_all();
        drain(0);
        drain(1);
    endtask

    task automatic clear_ovf();
        @(posedge clk);
        #1 clr_overflow = 1'b1;
        @(posedge clk);
        #1 clr_overflow = 1'b0;
        movf[0] = 1'b0;
        movf[1] = 1'b0;
    endtask

    function automatic logic [7:0] rand_byte();
        int unsigned r;
        r = $urandom_range(0, 9);
        if (r == 0) return 8'h00;
        if (r <= 4) return 8'($urandom_range(0, 127));
        if (r <= 6) return 8'($urandom_range(128, 239));
        if (r == 7) return 8'h90 | 8'($urandom_range(0, 1));
        if (r == 8) return 8'($urandom_range(248, 255));
        return 8'($urandom_range(240, 247));
    endfunction

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        if_a.msg_ready = 1'b0;
        if_b.msg_ready = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", if_a.msg_valid, 0);
        check("rst_data", if_a.msg_data, 0);
        check("rst_count", count_a, 0);
        check("rst_overflow", ovf_a, 0);
        check("rst_rx_err", err_a, 0);
        reset_n = 1'b1;
        repeat (2) @(posedge clk);

        // Basic message with exact valid latency
        send_byte(8'h90, 1'b1, 0);
        send_byte(8'h3C, 1'b1, 0);
        send_byte(8'h64, 1'b1, 1);
        check("basic_data", if_a.msg_data, 24'h903C64);
        check_state();

        // Running status; Note-On velocity 0 normalised on A only
        send_byte(8'h3E, 1'b1, 0);
        send_byte(8'h00, 1'b1, 0);
        check_state();
        drain_all();

        // Real-time interleave, 1-byte message, then SysEx discards data
        send_byte(8'hC5, 1'b1, 0);
        send_byte(8'hF8, 1'b1, 0);
        send_byte(8'h07, 1'b1, 0);
        check_state();
        drain_all();
        send_byte(8'hF0, 1'b1, 0);
        send_byte(8'h12, 1'b1, 0);
        check_state();

        // Channel filter
        send_byte(8'h91, 1'b1, 0);
        send_byte(8'h40, 1'b1, 0);
        send_byte(8'h7F, 1'b1, 0);
        send_byte(8'h90, 1'b1, 0);
        send_byte(8'h40, 1'b1, 0);
        send_byte(8'h7F, 1'b1, 0);
        send_byte(8'hFE, 1'b1, 0);
        check_state();
        drain_all();

        // Overflow, then clear
        send_byte(8'hF8, 1'b1, 0);
        send_byte(8'hFA, 1'b1, 0);
        send_byte(8'hFB, 1'b1, 0);
        send_byte(8'hFC, 1'b1, 0);
        send_byte(8'hFE, 1'b1, 0);
        check_state();
        drain_all();
        clear_ovf();
        check_state();

        // Pointer wrap
        for (int i = 0; i < 6; i++) begin
            send_byte(8'($urandom_range(248, 255)), 1'b1, 0);
            check_state();
            drain_all();
        end

        // Push and pop on a full queue
        send_byte(8'hF8, 1'b1, 0);
        send_byte(8'hF9, 1'b1, 0);
        send_byte(8'hFA, 1'b1, 0);
        send_byte(8'hFB, 1'b1, 0);
        send_byte(8'hFC, 1'b1, 2);
        check_state();
        drain_all();
        clear_ovf();

        // Framing error clears running status
        send_byte(8'h90, 1'b1, 0);
        send_byte(8'h3C, 1'b0, 3);
        send_byte(8'h64, 1'b1, 0);
        check_state();

        // Randomised bursts
        for (int round = 0; round < 10; round++) begin
            int n;
            n = $urandom_range(1, 6);
            for (int k = 0; k < n; k++) send_byte(rand_byte(), 1'b1, 0);
            check_state();
            drain_all();
            clear_ovf();
        end

        // Reset mid-byte with two messages queued
        send_byte(8'hF8, 1'b1, 0);
        send_byte(8'hFA, 1'b1, 0);
        check_state();
        @(posedge clk);
        #1 midi_in = 1'b0;
        repeat (50) @(posedge clk);
        #3 reset_n = 1'b0;
        #1;
        check("mid_rst_valid", if_a.msg_valid, 0);
        check("mid_rst_data", if_a.msg_data, 0);
        check("mid_rst_count", count_a, 0);
        check("mid_rst_overflow", ovf_a, 0);
        check("mid_rst_rx_err", err_a, 0);
        midi_in = 1'b1;
        model_reset();
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (2) @(posedge clk);
        send_byte(8'h92, 1'b1, 0);
        send_byte(8'h30, 1'b1, 0);
        send_byte(8'h00, 1'b1, 0);
        check_state();
        drain_all();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/midi_rx_queue.md
# midi_rx_queue

Parametrised MIDI input stage: receives the serial MIDI stream, parses it into complete 3-byte messages (running status, real-time pass-through, channel filtering, optional Note-Off normalisation) and buffers them in a first-word-fall-through queue with a valid/ready handshake. It sits between the board's `midi_in` pin and the message consumers (the 7-segment note display and the WIZ830MJ network sender). It replaces the fixed single-register receiver, which has no buffering, no backpressure and no loss indication.

## Interface
- `CLK_HZ`, 50_000_000: clk frequency in Hz.
- `BAUD`, 31250: MIDI bit rate. `DIV = CLK_HZ/BAUD` (integer division, truncated). DIV must be ≥ 8.
- `DEPTH`, 8: queue depth in messages. Must be a power of 2, ≥ 2.
- `CHAN_MASK`, 16'hFFFF: bit n = 1 accepts channel n (0–15).
- `NOTE_OFF_NORM`, 1: when 1, `9n kk 00` is emitted as `8n kk 00`.
- `clk` in 1: system clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `midi_in` in 1: raw MIDI serial input. Asynchronous; idle high.
- `msg_data` out 24: head message `{status, data1, data2}`. Unused bytes are 0.
- `msg_valid` out 1: the queue is non-empty.
- `msg_ready` in 1: consumer accepts the head message.
- `count` out $clog2(DEPTH)+1: number of messages in the queue.
- `overflow` out 1: sticky flag; a message was dropped because the queue was full.
- `clr_overflow` in 1: synchronous clear for `overflow`.
- `rx_err` out 1: one-cycle pulse on a framing error.

## Operation
- **Input synchroniser:** `midi_in` passes through 2 flops before use.
- **Receiver FSM:** IDLE → START → DATA → STOP.
  - IDLE: a high-to-low transition moves to START.
  - START: sample at DIV/2 cycles. If low, go to DATA. If high, it was a false start; return to IDLE with no error.
  - DATA: 8 samples spaced DIV cycles apart, LSB first.
  - STOP: 1 sample DIV cycles later. If high, the byte is delivered to the parser. If low, pulse `rx_err`, discard the byte, clear running status, then return to IDLE. A new falling edge is not accepted until the line has been seen high.
- **Parser**, per delivered byte:
  - F8–FF (real-time): emit `{b,00,00}` immediately. The partial message and running status are left untouched.
  - F0–F7 (system common/SysEx): clear running status. Subsequent data bytes are discarded until the next channel status byte.
  - 80–EF: set running status to b and reset the data index. Expected data length is 1 for Cn/Dn and 2 for all others.
  - 00–7F, no running status: discard.
  - 00–7F, running status set: store as data1, then data2. When the expected length is reached, emit `{status,d1,d2}` (d2 = 00 for 1-byte messages) and reset the data index. Running status is retained.
- **Channel filter:** a channel message on channel n is emitted only if `CHAN_MASK[n]`. Real-time messages are never filtered.
- **Note-Off normalisation:** applied at emit time, after filtering.
- **Queue:** circular buffer of DEPTH × 24 bits.
  - Push when an emitted message arrives. Pop when `msg_valid && msg_ready`.
  - Full (count == DEPTH), push only: drop the message and set `overflow`.
  - Full, push and pop in the same cycle: both succeed and count stays DEPTH. No overflow.
  - Empty, push and pop in the same cycle: impossible, because `msg_valid` = 0.
  - Pointers wrap modulo DEPTH.
  - `msg_data` = 24'h0 when empty.
- **`overflow` priority:** if a set event and `clr_overflow` occur in the same cycle, set wins.

## Timing
- **Reset values:** `msg_data` = 0, `msg_valid` = 0, `count` = 0, `overflow` = 0, `rx_err` = 0. Receiver is in IDLE; running status and data index are cleared; queue pointers are 0.
- **Reset mid-operation:** any partial byte, partial message and all queued messages are lost.
- **Latency:** let S be the clk cycle of the stop-bit sample.
  - The parser registers the byte at the edge ending S.
  - The queue is written at the edge ending S+1.
  - When the queue was empty, `msg_valid` and `msg_data` are valid from cycle S+2.
- **`rx_err`:** high for exactly cycle S+1 on a framing error.
- **Handshake:** pop occurs at the clk edge where `msg_valid && msg_ready`. The next entry (or 0 when the queue becomes empty) appears the following cycle. `msg_data` is stable while `msg_valid && !msg_ready`.
- **`count`:** updates on the same edge as the push or pop.
- **Parser pacing:** one byte at most every 10·DIV cycles, so no input stall is needed.

## Test plan
All tests use CLK_HZ = 1_000_000, BAUD = 31250 (DIV = 32) and DEPTH = 4.
- **Basic message:** send `90 3C 64`, `msg_ready` = 0 → `msg_valid` rises 2 cycles after the third stop sample. `msg_data` = 24'h903C64, `count` = 1.
- **Running status and normalisation:** send `90 3C 64 3E 00`. Pop both → 24'h903C64, then 24'h803E00. Repeat with NOTE_OFF_NORM = 0 → second message is 24'h903E00.
- **Real-time interleave and 1-byte message:** send `C5 F8 07` → 24'hF80000 first, then 24'hC50700. A following `F0 12` → nothing is emitted.
- **Channel filter:** with CHAN_MASK = 16'h0001, send `91 40 7F` then `90 40 7F` → only 24'h90407F is queued. `FE` always passes.
- **Overflow and wrap:** with `msg_ready` = 0, send 5 messages → `count` = 4 and `overflow` = 1. The 5th is lost and the first 4 pop in order. `clr_overflow` clears the flag. Then 6 push/pop cycles exercise pointer wrap. Push and pop while full → `count` stays 4 and `overflow` stays 0.
- **Framing error and reset:** force the stop bit low → `rx_err` is high for 1 cycle and nothing is queued. Assert `reset_n` low mid-byte with 2 messages queued → all outputs return to their reset values immediately.
